// File: rtl/addsub_arb_16b.sv
// Round-robin arbiter sharing one 16-bit Kogge-Stone add/sub/negate unit among NREQ requesters.
// Optional signed-overflow output o_ovf is built when ADDSUB_ARB_OVF_EN is defined.
module addsub_arb_16b #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    i_req,
  input  logic [2*NREQ-1:0]  i_op,
  input  logic [16*NREQ-1:0] i_a,
  input  logic [16*NREQ-1:0] i_b,
  output logic [NREQ-1:0]    o_gnt,
  output logic               o_valid,
  input  logic               i_out_ready,
  output logic [IDW-1:0]     o_id,
  output logic [15:0]        o_r,
  output logic               o_cout
`ifdef ADDSUB_ARB_OVF_EN
  ,
  output logic               o_ovf
`endif
);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpNeg = 2'b10;

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] k;
  logic [IDW:0]   k_w;
  logic           gnt_any;
  logic           slot_free;

  always_comb begin
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    o_gnt     = '0;
    k_w       = '0;
    k         = '0;
    slot_free = !o_valid || i_out_ready;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k_w = {1'b0, ptr_q} + (IDW+1)'(i);
      if (k_w >= (IDW+1)'(NREQ)) k_w = k_w - (IDW+1)'(NREQ);
      k = k_w[IDW-1:0];
      if (!gnt_any && i_req[k] && slot_free && !rst) begin
        gnt_any  = 1'b1;
        gnt_idx  = k;
        o_gnt[k] = 1'b1;
      end
    end
  end

  assign ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

  logic [1:0]  op_sel;
  logic [15:0] a_sel;
  logic [15:0] b_sel;
  logic [15:0] x;
  logic [15:0] y;
  logic        c0;

  assign op_sel = i_op[{gnt_idx, 1'b0} +: 2];
  assign a_sel  = i_a[{gnt_idx, 4'b0000} +: 16];
  assign b_sel  = i_b[{gnt_idx, 4'b0000} +: 16];

  // Operand inversion: SUB is A + ~B + 1, NEG is ~A + 0 + 1, PASS is A + 0.
  always_comb begin
    x  = a_sel;
    y  = '0;
    c0 = 1'b0;
    case (op_sel)
      OpAdd: y = b_sel;
      OpSub: begin
        y  = ~b_sel;
        c0 = 1'b1;
      end
      OpNeg: begin
        x  = ~a_sel;
        c0 = 1'b1;
      end
      default: ;
    endcase
  end

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] gp;
  logic [15:0] pp;
  logic [16:0] carry;
  logic [15:0] sum;

  // Kogge-Stone prefix tree, log2(16)=4 levels; carry-in folded in after the tree.
  always_comb begin
    g  = x & y;
    p  = x ^ y;
    gp = '0;
    pp = '0;
    for (int l = 0; l < 4; l++) begin
      gp = g;
      pp = p;
      for (int i = 0; i < 16; i++) begin
        if (i >= (1 << l)) begin
          g[i] = gp[i] | (pp[i] & gp[i - (1 << l)]);
          p[i] = pp[i] & pp[i - (1 << l)];
        end
      end
    end
    carry = {g | (p & {16{c0}}), c0};
    sum   = (x ^ y) ^ carry[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      o_valid <= 1'b0;
      o_id    <= '0;
      o_r     <= '0;
      o_cout  <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
      o_ovf   <= 1'b0;
`endif
    end else if (gnt_any) begin
      ptr_q   <= ptr_d;
      o_valid <= 1'b1;
      o_id    <= gnt_idx;
      o_r     <= sum;
      o_cout  <= carry[16];
`ifdef ADDSUB_ARB_OVF_EN
      o_ovf   <= (x[15] == y[15]) && (sum[15] != x[15]);
`endif
    end else if (i_out_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: doc/addsub_arb_16b.md
Name: addsub_arb_16b

Overview:
- Round-robin arbiter and sequencer sharing one 16-bit Kogge-Stone add/subtract/negate unit (ksa_top_16b plus notgate operand inversion) among NREQ butterfly-stage requesters of the 64-point FFT datapath.
- Accepts at most one operation per cycle and computes it combinationally.
- Registers the result with requester ID into a single output slot under valid/ready backpressure.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, requester-ID width; must equal clog2(NREQ), with a minimum of 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  NREQ  per-requester request; bit k belongs to requester k.
- i_op  in  2*NREQ  per-requester opcode; bits [2k+1:2k] belong to requester k.
- i_a  in  16*NREQ  per-requester operand A; bits [16k+15:16k].
- i_b  in  16*NREQ  per-requester operand B; same slicing.
- o_gnt  out  NREQ  one-hot grant; requester k's operation is accepted in any cycle where o_gnt[k]=1.
- o_valid  out  1  output slot holds a result.
- i_out_ready  in  1  consumer accepts the result in any cycle where o_valid=1 and i_out_ready=1.
- o_id  out  IDW  requester index of the held result.
- o_r  out  16  result.
- o_cout  out  1  adder carry-out of the held operation.

Behaviour:
- Reset (asynchronous, active-high):
  - o_valid=0, o_id=0, o_r=0, o_cout=0.
  - Round-robin pointer ptr=0.
  - o_gnt is combinational and is 0 while rst=1.
- Opcodes, computed through one shared ksa_top_16b instance:
  - 00 ADD: A + B, c0=0.
  - 01 SUB: A + ~B, c0=1.
  - 10 NEG: ~A + 0, c0=1.
  - 11 PASS: A + 0, c0=0.
- Result width:
  - o_r = sum[15:0], modulo 2^16.
  - o_cout = carry-out of the 16-bit addition.
- Slot free condition: free = !o_valid || i_out_ready.
- Arbitration (combinational, same cycle):
  - If free and any i_req bit is set, grant the first set bit searching from index ptr upward, wrapping NREQ-1 -> 0.
  - o_gnt is exactly one-hot or zero.
  - If the slot is not free, o_gnt=0 regardless of requests.
- Pointer update:
  - On a grant to index g, ptr <= (g+1) mod NREQ.
  - With no grant, ptr is held.
- Latency: the result appears at the next rising edge (o_valid=1, o_id=g, o_r/o_cout registered). Grant-to-valid is 1 cycle.
- Output slot:
  - If o_valid=1 and i_out_ready=1 with no new grant, o_valid <= 0. o_id, o_r, o_cout keep their last values.
  - If o_valid=1 and i_out_ready=1 with a grant in the same cycle, the slot is overwritten with the new result and o_valid stays 1. Full throughput is 1 op/cycle.
  - If o_valid=1 and i_out_ready=0, o_id, o_r, o_cout are stable and o_gnt=0 (stall).
- Requester contract:
  - A requester holds i_req, i_op, i_a, i_b stable until it sees its o_gnt bit.
  - Deasserting i_req before the grant withdraws the request with no side effects.
- Fairness: with all NREQ requesters continuously asserting and the consumer always ready, each requester is granted exactly once in every NREQ consecutive cycles.
- Boundary values:
  - NEG 0x0000 gives o_r=0x0000, o_cout=1.
  - NEG 0x8000 gives o_r=0x8000, o_cout=0.
  - SUB x - x gives o_r=0x0000, o_cout=1.
- Reset mid-operation: the held result is discarded (o_valid=0) and ptr=0 immediately. No grant is issued while rst=1.

Optional Feature:
- Macro: ADDSUB_ARB_OVF_EN.
- When defined:
  - Adds output port o_ovf (1 bit), registered with o_r and reset to 0.
  - o_ovf = two's-complement signed overflow of the executed operation: operand sign bits equal (after the inversion applied by the opcode) and the result sign differs from them.
  - Example: NEG 0x8000 gives o_ovf=1.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then only requester 2 asserts ADD 0x1234+0x0FF0 -> o_gnt=0100 in the same cycle; next cycle o_valid=1, o_id=2, o_r=0x2224, o_cout=0.
- All 4 requesters assert continuously, i_out_ready=1 -> grants 0,1,2,3,0,1... one per cycle; o_id follows the same sequence one cycle later.
- SUB 0x0005-0x0007 -> o_r=0xFFFE, o_cout=0; NEG 0x0000 -> o_r=0x0000, o_cout=1; PASS 0xBEEF -> o_r=0xBEEF, o_cout=0.
- Result held, i_out_ready=0 for 3 cycles with requests pending -> o_gnt=0 and o_r/o_id stable for all 3 cycles; when i_out_ready rises, a grant is issued in that same cycle and the slot is replaced on the next edge.
- rst asserted while o_valid=1 and ptr=3 -> o_valid=0 immediately; after release, requests on 1 and 3 -> requester 1 is granted first (ptr restarted at 0).
- ADDSUB_ARB_OVF_EN defined: ADD 0x7FFF+0x0001 -> o_r=0x8000, o_ovf=1; NEG 0x8000 -> o_ovf=1; ADD 0x0001+0x0001 -> o_ovf=0.
